// File: rtl/thread_seq.sv
// thread_seq: four-thread round-robin instruction fetch sequencer with
// per-thread PCs, branch redirect, and squash of in-flight fetches.
module thread_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  run_mask,
    output logic        f_enable,
    output logic        write_mode,
    output logic [31:0] addr,
    output logic [1:0]  thread,
    input  logic [31:0] data_i,
    input  logic        ack,
    input  logic        br_valid,
    input  logic [1:0]  br_thread,
    input  logic [31:0] br_target,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  inst_thread,
    input  logic        inst_ready
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pc [4];
    logic [31:0] pc_n [4];
    logic [1:0]  last, last_n, sel, thread_n, inst_thread_n;
    logic        kill, kill_n, f_enable_n, inst_valid_n, hit_req, accept;
    logic [31:0] addr_n, inst_n, inst_pc_n;

    assign write_mode = 1'b0;

    // Nearest enabled thread after the last issued one; falls back to last itself.
    always_comb begin
        sel = last;
        for (int k = 3; k >= 1; k--)
            if (run_mask[last + 2'(k)]) sel = last + 2'(k);
    end

    always_comb begin
        state_n       = state;
        f_enable_n    = f_enable;
        addr_n        = addr;
        thread_n      = thread;
        inst_valid_n  = inst_valid;
        inst_n        = inst;
        inst_pc_n     = inst_pc;
        inst_thread_n = inst_thread;
        last_n        = last;
        kill_n        = kill;
        accept        = 1'b0;
        hit_req       = br_valid && br_thread == thread;
        case (state)
            IDLE: if (|run_mask) begin
                state_n    = REQ;
                f_enable_n = 1'b1;
                thread_n   = sel;
                addr_n     = (br_valid && br_thread == sel) ? br_target : pc[sel];
            end
            REQ: if (ack) begin
                f_enable_n = 1'b0;
                kill_n     = 1'b0;
                if (kill || hit_req) begin
                    state_n = IDLE;
                    last_n  = thread;
                end else begin
                    state_n       = HOLD;
                    inst_valid_n  = 1'b1;
                    inst_n        = data_i;
                    inst_pc_n     = addr;
                    inst_thread_n = thread;
                end
            end else if (hit_req) begin
                kill_n = 1'b1;
            end
            HOLD: if (inst_ready) begin
                accept       = 1'b1;
                inst_valid_n = 1'b0;
                last_n       = inst_thread;
                state_n      = IDLE;
            end else if (br_valid && br_thread == inst_thread) begin
                inst_valid_n = 1'b0;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Redirect beats the post-accept increment on the same thread.
        for (int i = 0; i < 4; i++)
            pc_n[i] = (br_valid && br_thread == 2'(i)) ? br_target :
                      (accept && inst_thread == 2'(i)) ? inst_pc + PC_STEP : pc[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_enable    <= 1'b0;
            addr        <= '0;
            thread      <= '0;
            inst_valid  <= 1'b0;
            inst        <= '0;
            inst_pc     <= '0;
            inst_thread <= '0;
            kill        <= 1'b0;
            last        <= 2'd3;
            for (int i = 0; i < 4; i++) pc[i] <= RESET_PC;
        end else begin
            f_enable    <= f_enable_n;
            addr        <= addr_n;
            thread      <= thread_n;
            inst_valid  <= inst_valid_n;
            inst        <= inst_n;
            inst_pc     <= inst_pc_n;
            inst_thread <= inst_thread_n;
            kill        <= kill_n;
            last        <= last_n;
            for (int i = 0; i < 4; i++) pc[i] <= pc_n[i];
        end
    end
endmodule

// File: tb/tb_thread_seq.sv
// tb_thread_seq: randomized scoreboard bench for thread_seq, checked against
// a round-robin model holding per-thread PCs and the last accepted thread.
module tb_thread_seq;
    logic        clk = 0;
    logic        rst = 1;
    logic [3:0]  run_mask = 0;
    logic        ack = 0;
    logic        br_valid = 0;
    logic        inst_ready = 0;
    logic [31:0] data_i = 0;
    logic [31:0] br_target = 0;
    logic [1:0]  br_thread = 0;
    logic        f_enable, write_mode, inst_valid;
    logic [31:0] addr, inst, inst_pc;
    logic [1:0]  thread, inst_thread;

    int          checks = 0;
    int          errors = 0;
    logic [33:0] fq[$];
    logic [97:0] iq[$];
    logic [33:0] fe;
    logic [97:0] ie;
    logic [31:0] mpc [4];
    logic [1:0]  mlast;
    logic        pf = 0;
    logic [3:0]  m;

    thread_seq dut (
        .clk(clk), .rst(rst), .run_mask(run_mask), .f_enable(f_enable),
        .write_mode(write_mode), .addr(addr), .thread(thread), .data_i(data_i),
        .ack(ack), .br_valid(br_valid), .br_thread(br_thread), .br_target(br_target),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_thread(inst_thread), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mpc[i] = 32'h0000_0000;
        mlast = 2'd3;
    endtask

    // Round robin: first enabled thread strictly after the last accepted one.
    function automatic logic [1:0] pick(input logic [3:0] mask);
        logic [1:0] c;
        for (int k = 1; k <= 4; k++) begin
            c = 2'(mlast + k);
            if (mask[c]) return c;
        end
        return 2'd0;
    endfunction

    task automatic wait_fetch(output bit seen);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = f_enable;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: f_enable=%b required 1 within 20 cycles", f_enable);
        end
    endtask

    // bm: 0 none, 1 kill in-flight, 2 redirect other in REQ, 3 squash in HOLD,
    //     4 redirect same thread with accept, 5 redirect other in HOLD
    task automatic xact(input logic [3:0] mk, input int dly, input int hw, input int bm,
                        input logic [31:0] tgt, input logic [31:0] d);
        logic [1:0]  t, o;
        logic [31:0] a;
        bit          seen;
        t = pick(mk);
        o = t + 2'd1;
        a = mpc[t];
        run_mask = mk;
        fq.push_back({t, a});
        wait_fetch(seen);
        if (!seen) begin
            run_mask = 0;
            return;
        end
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            br_valid = 0;
            run_mask = 4'($urandom);
            if (i == 0 && (bm == 1 || bm == 2)) begin
                br_valid  = 1;
                br_thread = bm == 1 ? t : o;
                br_target = tgt;
                mpc[bm == 1 ? t : o] = tgt;
            end
            if (i == dly - 1) begin
                ack    = 1;
                data_i = d;
            end
        end
        @(posedge clk); #1;
        ack = 0;
        br_valid = 0;
        data_i = $urandom;
        if (bm == 1) begin
            run_mask = 0;
            mlast = t;
            @(negedge clk);
            chk("kill_discard", {inst_valid, f_enable}, 0);
            return;
        end
        if (bm == 3) begin
            br_valid  = 1;
            br_thread = t;
            br_target = tgt;
            @(negedge clk);
            chk("squash_pre", {inst_valid, inst}, {1'b1, d});
            @(posedge clk); #1;
            br_valid = 0;
            run_mask = 0;
            mpc[t] = tgt;
            @(negedge clk);
            chk("squash_valid", inst_valid, 0);
            return;
        end
        if (bm == 5) begin
            br_valid  = 1;
            br_thread = o;
            br_target = tgt;
            mpc[o] = tgt;
        end
        for (int j = 0; j < hw; j++) begin
            @(negedge clk);
            chk("hold_stable", {inst_valid, f_enable, inst, inst_pc, inst_thread},
                {1'b1, 1'b0, d, a, t});
            @(posedge clk); #1;
            br_valid = 0;
            run_mask = 4'($urandom);
        end
        iq.push_back({d, a, t});
        inst_ready = 1;
        if (bm == 4) begin
            br_valid  = 1;
            br_thread = t;
            br_target = tgt;
        end
        @(posedge clk); #1;
        inst_ready = 0;
        br_valid = 0;
        run_mask = 0;
        mpc[t] = bm == 4 ? tgt : a + 32'd4;
        mlast = t;
    endtask

    task automatic idle_check(input int n);
        int hi = 0;
        run_mask = 0;
        repeat (n) begin
            @(negedge clk);
            hi += int'(f_enable);
        end
        chk("idle_no_fetch", hi, 0);
    endtask

    task automatic redirect_idle(input logic [1:0] t, input logic [31:0] tgt);
        run_mask  = 0;
        br_valid  = 1;
        br_thread = t;
        br_target = tgt;
        @(posedge clk); #1;
        br_valid = 0;
        mpc[t] = tgt;
    endtask

    task automatic reset_mid_req();
        bit         seen;
        logic [1:0] t;
        t = pick(4'b1111);
        run_mask = 4'b1111;
        fq.push_back({t, mpc[t]});
        wait_fetch(seen);
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk("reset_mid_req", {f_enable, addr, thread, inst_valid}, 0);
        run_mask = 0;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    // Monitor: compares every new fetch request and every accepted instruction.
    initial begin
        forever begin
            @(negedge clk);
            if (f_enable && !pf) begin
                if (fq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_unexpected: thread=%0d addr=%h required none", thread, addr);
                end else begin
                    fe = fq.pop_front();
                    chk("fetch", {thread, addr}, fe);
                end
            end
            pf = f_enable;
            if (inst_valid && inst_ready) begin
                if (iq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL inst_unexpected: inst=%h pc=%h required none", inst, inst_pc);
                end else begin
                    ie = iq.pop_front();
                    chk("inst", {inst, inst_pc, inst_thread}, ie);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        #12;
        chk("reset_outputs", {f_enable, write_mode, addr, thread, inst_valid, inst, inst_pc, inst_thread}, 0);
        @(negedge clk);
        rst = 0;
        repeat (5) xact(4'b1111, 2, 0, 0, 0, $urandom);
        repeat (4) xact(4'b0101, $urandom_range(1, 3), 0, 0, 0, $urandom);
        idle_check(20);
        xact(4'b1111, 2, 5, 0, 0, 32'hDEAD_BEEF);
        xact(4'b0010, 3, 0, 1, 32'h0000_1000, $urandom);
        xact(4'b0010, 2, 0, 0, 0, $urandom);
        redirect_idle(2'd0, 32'hFFFF_FFFC);
        xact(4'b0001, 2, 1, 0, 0, $urandom);
        xact(4'b0001, 2, 0, 0, 0, $urandom);
        xact(4'b1111, 2, 0, 3, 32'h0000_2000, $urandom);
        xact(4'b1111, 2, 2, 4, 32'h0000_3000, $urandom);
        xact(4'b1111, 2, 1, 5, 32'h0000_4000, $urandom);
        xact(4'b1111, 3, 0, 2, 32'h0000_5000, $urandom);
        xact(4'b1111, 1, 0, 1, 32'h0000_6000, $urandom);
        reset_mid_req();
        xact(4'b1111, 2, 0, 0, 0, $urandom);
        repeat (200) begin
            m = 4'($urandom);
            if (m == 0) idle_check(3);
            else xact(m, $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 5),
                      $urandom & 32'hFFFF_FFFC, $urandom);
        end
        repeat (4) @(negedge clk);
        chk("queues_drained", {fq.size(), iq.size()}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/thread_seq.md
THREAD_SEQ -- requirements
Module: thread_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, start PC of every thread after reset.
REQ-002 Parameter PC_STEP, default 4, PC increment per delivered instruction.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 run_mask  input  4  bit n = thread n eligible for issue.
REQ-006 f_enable  output  1  fetch request to fetch stage.
REQ-007 write_mode  output  1  constant 0; instruction path is read-only.
REQ-008 addr  output  32  fetch address (PC of selected thread).
REQ-009 thread  output  2  thread id of current fetch.
REQ-010 data_i  input  32  fetched word, valid when ack=1.
REQ-011 ack  input  1  one-cycle fetch completion pulse.
REQ-012 br_valid  input  1  PC redirect strobe.
REQ-013 br_thread  input  2  thread being redirected.
REQ-014 br_target  input  32  new PC.
REQ-015 inst_valid  output  1  instruction available to decode.
REQ-016 inst  output  32  instruction word.
REQ-017 inst_pc  output  32  PC of inst.
REQ-018 inst_thread  output  2  thread of inst.
REQ-019 inst_ready  input  1  decode accepts when inst_valid && inst_ready.

Function
REQ-020 Block SHALL hold four 32-bit PCs and a 2-bit last-issued pointer.
REQ-021 FSM SHALL have states IDLE, REQ, HOLD.
REQ-022 IDLE: if any run_mask bit set, select first enabled thread cyclically after last-issued, drive addr/thread, set f_enable=1, go REQ next cycle; else stay IDLE.
REQ-023 REQ: hold f_enable, addr, thread stable until ack sampled 1; on that edge f_enable<=0, inst<=data_i, inst_pc<=addr, inst_thread<=thread, inst_valid<=1, go HOLD.
REQ-024 f_enable SHALL be low at least one full cycle between consecutive requests (fetch stage re-arms one cycle after ack).
REQ-025 HOLD: inst, inst_pc, inst_thread stable while inst_valid=1 and inst_ready=0.
REQ-026 HOLD with inst_ready=1: inst_valid<=0, PC[inst_thread]<=inst_pc+PC_STEP (mod 2^32, wraps FFFF_FFFC->0000_0000), last-issued<=inst_thread, go IDLE.
REQ-027 Issue throughput SHALL be at most one instruction per 3 cycles plus fetch latency; no speculative second request.
REQ-028 br_valid=1 SHALL write PC[br_thread]<=br_target on that edge in any state.
REQ-029 Redirect and PC increment to the same thread on the same edge: redirect wins.
REQ-030 Redirect to thread in REQ: set kill flag; on ack discard data, f_enable<=0, go IDLE, inst_valid stays 0, last-issued<=that thread.
REQ-031 Redirect to thread in HOLD without handshake that cycle: inst_valid<=0 next edge, go IDLE (squash; only permitted valid withdrawal).
REQ-032 Redirect in HOLD coinciding with inst_ready=1: handshake completes, instruction delivered, PC = br_target.
REQ-033 Redirect to a thread not in flight SHALL not disturb the current transaction.
REQ-034 Clearing a run_mask bit mid-transaction SHALL not abort it; only future selection affected.
REQ-035 ack sampled in IDLE or HOLD SHALL be ignored.

Reset
REQ-036 rst=1 SHALL immediately force: state IDLE, f_enable=0, write_mode=0, addr=0, thread=0, inst_valid=0, inst=0, inst_pc=0, inst_thread=0, kill=0, all PCs=RESET_PC, last-issued=3 (first pick thread 0).
REQ-037 Reset asserted mid-REQ SHALL drop f_enable the same cycle; first post-reset request starts no earlier than the first edge after rst falls.

Verification
REQ-038 run_mask=4'b1111, ack 2 cycles after each f_enable, inst_ready=1 -> fetch order threads 0,1,2,3,0 at addr 0,0,0,0,4.
REQ-039 run_mask=4'b0101 -> only threads 0,2 issue, alternating; run_mask=0 -> f_enable stays 0 for 20 cycles.
REQ-040 inst_ready=0 for 5 cycles with data_i=32'hDEAD_BEEF -> inst_valid and inst stable 5 cycles, no new f_enable until accept.
REQ-041 br_valid for thread 1, br_target=32'h0000_1000 while thread 1 in REQ -> ack data discarded, inst_valid stays 0, next thread-1 fetch addr=32'h0000_1000.
REQ-042 PC of thread 0 = 32'hFFFF_FFFC, accept -> next thread-0 addr = 32'h0000_0000.
REQ-043 rst pulsed during REQ -> f_enable 0 same cycle, all PCs 0, first fetch after release is thread 0 addr 0.
